// File: rtl/gemm_sched_pkg.sv
// Shared definitions for the GEMM tile scheduler: register offsets relative
// to the GEMM register base, FSM state encoding and register-field packers.
package gemm_sched_pkg;

  localparam logic [31:0] OFS_A_ADDR   = 32'd0;   // read: bit 0 = queue full
  localparam logic [31:0] OFS_B_ADDR   = 32'd4;
  localparam logic [31:0] OFS_C_ADDR   = 32'd8;
  localparam logic [31:0] OFS_A_STRIDE = 32'd12;
  localparam logic [31:0] OFS_B_STRIDE = 32'd16;
  localparam logic [31:0] OFS_CTRL     = 32'd20;
  localparam logic [31:0] OFS_DIM      = 32'd24;  // read: bit 0 = gemm done

  typedef enum logic [3:0] {
    S_IDLE,
    S_W_ASTR,
    S_W_BSTR,
    S_W_A,
    S_W_B,
    S_W_C,
    S_W_CTRL,
    S_W_DIM,
    S_RD_FULL,
    S_CHK_FULL,
    S_ADV,
    S_RD_DONE,
    S_CHK_DONE,
    S_FIN
  } state_e;

  // Tile size register: 5-bit fields msize | ksize<<5 | nsize<<10.
  function automatic logic [31:0] pack_dim(input logic [31:0] msize,
                                           input logic [31:0] ksize,
                                           input logic [31:0] nsize);
    return (msize & 32'h1f) | ((ksize & 32'h1f) << 5) | ((nsize & 32'h1f) << 10);
  endfunction

  // Control register: bit 1 = first k slice (clear accumulators), bit 0 = last k slice.
  function automatic logic [31:0] pack_ctrl(input logic first, input logic last);
    return {30'd0, first, last};
  endfunction

endpackage

// File: rtl/gemm_tile_iter.sv
// Tile index walker: k innermost, then m, then n. Produces the current tile
// origin, clipped tile sizes, first/last-k flags and a flag marking the final
// tile of the job.
module gemm_tile_iter #(
  parameter int BLK_N = 16,
  parameter int BLK_K = 16,
  parameter int BLK_M = 16,
  parameter int DIM_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             advance_i,
  input  logic [DIM_W-1:0] dim_m_i,
  input  logic [DIM_W-1:0] dim_k_i,
  input  logic [DIM_W-1:0] dim_n_i,
  output logic [DIM_W-1:0] m_o,
  output logic [DIM_W-1:0] k_o,
  output logic [DIM_W-1:0] n_o,
  output logic [DIM_W-1:0] msize_o,
  output logic [DIM_W-1:0] ksize_o,
  output logic [DIM_W-1:0] nsize_o,
  output logic             first_o,
  output logic             last_o,
  output logic             all_done_o
);

  logic [DIM_W-1:0] m_q, m_d, k_q, k_d, n_q, n_d;
  logic [DIM_W-1:0] rem_m, rem_k, rem_n;
  logic             m_end, k_end, n_end;

  // Remaining extent and end-of-dimension detection (one extra bit so idx+BLK cannot wrap).
  always_comb begin
    rem_m = dim_m_i - m_q;
    rem_k = dim_k_i - k_q;
    rem_n = dim_n_i - n_q;
    m_end = ({1'b0, m_q} + (DIM_W+1)'(BLK_M)) >= {1'b0, dim_m_i};
    k_end = ({1'b0, k_q} + (DIM_W+1)'(BLK_K)) >= {1'b0, dim_k_i};
    n_end = ({1'b0, n_q} + (DIM_W+1)'(BLK_N)) >= {1'b0, dim_n_i};
  end

  assign msize_o    = (rem_m > DIM_W'(BLK_M)) ? DIM_W'(BLK_M) : rem_m;
  assign ksize_o    = (rem_k > DIM_W'(BLK_K)) ? DIM_W'(BLK_K) : rem_k;
  assign nsize_o    = (rem_n > DIM_W'(BLK_N)) ? DIM_W'(BLK_N) : rem_n;
  assign first_o    = (k_q == '0);
  assign last_o     = k_end;
  assign all_done_o = k_end && m_end && n_end;
  assign m_o        = m_q;
  assign k_o        = k_q;
  assign n_o        = n_q;

  // Next tile indices: step k, carry into m, then into n.
  always_comb begin
    m_d = m_q;
    k_d = k_q;
    n_d = n_q;
    if (clear_i) begin
      m_d = '0;
      k_d = '0;
      n_d = '0;
    end else if (advance_i) begin
      if (!k_end) begin
        k_d = k_q + DIM_W'(BLK_K);
      end else begin
        k_d = '0;
        if (!m_end) begin
          m_d = m_q + DIM_W'(BLK_M);
        end else begin
          m_d = '0;
          n_d = n_end ? '0 : n_q + DIM_W'(BLK_N);
        end
      end
    end
  end

  // Index registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_q <= '0;
      k_q <= '0;
      n_q <= '0;
    end else begin
      m_q <= m_d;
      k_q <= k_d;
      n_q <= n_d;
    end
  end

endmodule

// File: rtl/gemm_tile_scheduler.sv
// GEMM tiling sequencer: walks an MxKxN job tile by tile and programs the GEMM
// register block over the system bus, waiting on queue-full and final done.
// Optional build macro GEMM_SCHED_PERF_EN adds busy-cycle and stall counters.
//
// state      | meaning
// -----------+-----------------------------------------------
// IDLE       | waiting for start
// W_ASTR     | write A stride (K)
// W_BSTR     | write B stride (N)
// W_A        | write tile A address
// W_B        | write tile B address
// W_C        | write tile C address
// W_CTRL     | write first/last control
// W_DIM      | write packed tile sizes
// RD_FULL    | read queue-full flag
// CHK_FULL   | full -> re-read, else advance
// ADV        | step tile indices or finish walking
// RD_DONE    | read gemm done flag
// CHK_DONE   | not done -> re-read, else finish
// FIN        | one-cycle done pulse
module gemm_tile_scheduler
  import gemm_sched_pkg::*;
#(
  parameter int          BLK_N     = 16,
  parameter int          BLK_K     = 16,
  parameter int          BLK_M     = 16,
  parameter int          DIM_W     = 16,
  parameter logic [31:0] BASE_ADDR = 32'h9000_0000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [DIM_W-1:0] dim_m,
  input  logic [DIM_W-1:0] dim_k,
  input  logic [DIM_W-1:0] dim_n,
  input  logic [31:0]      a_base,
  input  logic [31:0]      b_base,
  input  logic [31:0]      c_base,
  output logic             busy,
  output logic             done,
  output logic             system_bus_en,
  output logic             system_bus_rdwr,
  output logic [31:0]      system_bus_addr,
  output logic [31:0]      system_bus_wr_data,
  input  logic [31:0]      system_bus_rd_data
`ifdef GEMM_SCHED_PERF_EN
  ,
  output logic [31:0]      perf_cycles,
  output logic [31:0]      perf_stall
`endif
);

  state_e           state_q, state_d;
  logic [DIM_W-1:0] dim_m_q, dim_k_q, dim_n_q;
  logic [31:0]      a_base_q, b_base_q, c_base_q;
  logic             accept, zero_dim, advance;
  logic [DIM_W-1:0] m_idx, k_idx, n_idx, msize, ksize, nsize;
  logic             first, last, all_done;
  logic [31:0]      tile_a, tile_b, tile_c;
  logic             rd_unused;

  assign accept    = (state_q == S_IDLE) && start;
  assign zero_dim  = (dim_m == '0) || (dim_k == '0) || (dim_n == '0);
  assign advance   = (state_q == S_ADV) && !all_done;
  assign rd_unused = ^system_bus_rd_data[31:1];

  gemm_tile_iter #(
    .BLK_N (BLK_N),
    .BLK_K (BLK_K),
    .BLK_M (BLK_M),
    .DIM_W (DIM_W)
  ) u_iter (
    .clk        (clk),
    .rst        (rst),
    .clear_i    (accept),
    .advance_i  (advance),
    .dim_m_i    (dim_m_q),
    .dim_k_i    (dim_k_q),
    .dim_n_i    (dim_n_q),
    .m_o        (m_idx),
    .k_o        (k_idx),
    .n_o        (n_idx),
    .msize_o    (msize),
    .ksize_o    (ksize),
    .nsize_o    (nsize),
    .first_o    (first),
    .last_o     (last),
    .all_done_o (all_done)
  );

  // Job parameters are captured only when a start is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      dim_m_q  <= '0;
      dim_k_q  <= '0;
      dim_n_q  <= '0;
      a_base_q <= '0;
      b_base_q <= '0;
      c_base_q <= '0;
    end else if (accept) begin
      dim_m_q  <= dim_m;
      dim_k_q  <= dim_k;
      dim_n_q  <= dim_n;
      a_base_q <= a_base;
      b_base_q <= b_base;
      c_base_q <= c_base;
    end
  end

  // Tile addresses; B points at the last k row of the slice, all modulo 2^32.
  always_comb begin
    tile_a = a_base_q + 32'(k_idx) + 32'(m_idx) * 32'(dim_k_q);
    tile_b = b_base_q + 32'(n_idx) + (32'(k_idx) + 32'(ksize) - 32'd1) * 32'(dim_n_q);
    tile_c = c_base_q + 32'(n_idx) + 32'(m_idx) * 32'(dim_n_q);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic and bus/status outputs.
  always_comb begin
    state_d            = state_q;
    busy               = 1'b1;
    done               = 1'b0;
    system_bus_en      = 1'b0;
    system_bus_rdwr    = 1'b0;
    system_bus_addr    = '0;
    system_bus_wr_data = '0;
    unique case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_d = zero_dim ? S_FIN : S_W_ASTR;
      end
      S_W_ASTR: begin
        system_bus_en      = 1'b1;
        system_bus_rdwr    = 1'b1;
        system_bus_addr    = BASE_ADDR + OFS_A_STRIDE;
        system_bus_wr_data = 32'(dim_k_q);
        state_d            = S_W_BSTR;
      end
      S_W_BSTR: begin
        system_bus_en      = 1'b1;
        system_bus_rdwr    = 1'b1;
        system_bus_addr    = BASE_ADDR + OFS_B_STRIDE;
        system_bus_wr_data = 32'(dim_n_q);
        state_d            = S_W_A;
      end
      S_W_A: begin
        system_bus_en      = 1'b1;
        system_bus_rdwr    = 1'b1;
        system_bus_addr    = BASE_ADDR + OFS_A_ADDR;
        system_bus_wr_data = tile_a;
        state_d            = S_W_B;
      end
      S_W_B: begin
        system_bus_en      = 1'b1;
        system_bus_rdwr    = 1'b1;
        system_bus_addr    = BASE_ADDR + OFS_B_ADDR;
        system_bus_wr_data = tile_b;
        state_d            = S_W_C;
      end
      S_W_C: begin
        system_bus_en      = 1'b1;
        system_bus_rdwr    = 1'b1;
        system_bus_addr    = BASE_ADDR + OFS_C_ADDR;
        system_bus_wr_data = tile_c;
        state_d            = S_W_CTRL;
      end
      S_W_CTRL: begin
        system_bus_en      = 1'b1;
        system_bus_rdwr    = 1'b1;
        system_bus_addr    = BASE_ADDR + OFS_CTRL;
        system_bus_wr_data = pack_ctrl(first, last);
        state_d            = S_W_DIM;
      end
      S_W_DIM: begin
        system_bus_en      = 1'b1;
        system_bus_rdwr    = 1'b1;
        system_bus_addr    = BASE_ADDR + OFS_DIM;
        system_bus_wr_data = pack_dim(32'(msize), 32'(ksize), 32'(nsize));
        state_d            = S_RD_FULL;
      end
      S_RD_FULL: begin
        system_bus_en   = 1'b1;
        system_bus_addr = BASE_ADDR + OFS_A_ADDR;
        state_d         = S_CHK_FULL;
      end
      S_CHK_FULL: begin
        state_d = system_bus_rd_data[0] ? S_RD_FULL : S_ADV;
      end
      S_ADV: begin
        state_d = all_done ? S_RD_DONE : S_W_ASTR;
      end
      S_RD_DONE: begin
        system_bus_en   = 1'b1;
        system_bus_addr = BASE_ADDR + OFS_DIM;
        state_d         = S_CHK_DONE;
      end
      S_CHK_DONE: begin
        state_d = system_bus_rd_data[0] ? S_FIN : S_RD_DONE;
      end
      S_FIN: begin
        busy    = 1'b0;
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        busy    = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

`ifdef GEMM_SCHED_PERF_EN
  logic [31:0] perf_cycles_q, perf_stall_q;

  // Busy-cycle and queue-full stall counters; cleared by an accepted start, held after done.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_cycles_q <= '0;
      perf_stall_q  <= '0;
    end else if (accept) begin
      perf_cycles_q <= '0;
      perf_stall_q  <= '0;
    end else begin
      if (busy) perf_cycles_q <= perf_cycles_q + 32'd1;
      if ((state_q == S_CHK_FULL) && system_bus_rd_data[0]) perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_cycles = perf_cycles_q;
  assign perf_stall  = perf_stall_q;
`endif

endmodule

// File: tb/tb_gemm_tile_scheduler.sv
// Directed bench for gemm_tile_scheduler with a write scoreboard and a small
// GEMM register model answering queue-full and done polls.
module tb_gemm_tile_scheduler;

  localparam logic [31:0] BASE = 32'h9000_0000;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] dim_m = '0, dim_k = '0, dim_n = '0;
  logic [31:0] a_base = '0, b_base = '0, c_base = '0;
  logic        busy, done, bus_en, rdwr;
  logic [31:0] addr, wr_data;
  logic [31:0] rd_data = '0;

  int total = 0;
  int bad = 0;
  wr_t sb[$];

  int full_ones = 0;
  int done_zeros = 0;
  int rd_full_cnt = 0;
  int rd_done_cnt = 0;
  int bus_en_cnt = 0;
  int done_cnt = 0;
  int astr_cnt = 0;
  int astr_full_snap = 0;
  logic [31:0] nxt_rd = '0;

  gemm_tile_scheduler dut (
    .clk                (clk),
    .rst                (rst),
    .start              (start),
    .dim_m              (dim_m),
    .dim_k              (dim_k),
    .dim_n              (dim_n),
    .a_base             (a_base),
    .b_base             (b_base),
    .c_base             (c_base),
    .busy               (busy),
    .done               (done),
    .system_bus_en      (bus_en),
    .system_bus_rdwr    (rdwr),
    .system_bus_addr    (addr),
    .system_bus_wr_data (wr_data),
    .system_bus_rd_data (rd_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] off, input logic [31:0] data);
    wr_t e;
    e.a = BASE + off;
    e.d = data;
    sb.push_back(e);
  endtask

  task automatic push_tile(input logic [31:0] astr, input logic [31:0] bstr,
                           input logic [31:0] ta, input logic [31:0] tb,
                           input logic [31:0] tc, input logic [31:0] ctrl,
                           input logic [31:0] dim);
    push(32'd12, astr);
    push(32'd16, bstr);
    push(32'd0,  ta);
    push(32'd4,  tb);
    push(32'd8,  tc);
    push(32'd20, ctrl);
    push(32'd24, dim);
  endtask

  task automatic start_job(input logic [15:0] m, input logic [15:0] k, input logic [15:0] n,
                           input logic [31:0] ab, input logic [31:0] bb, input logic [31:0] cb);
    @(negedge clk);
    dim_m = m; dim_k = k; dim_n = n;
    a_base = ab; b_base = bb; c_base = cb;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int maxc);
    int i;
    for (i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (done === 1'b1) break;
    end
    check("done_within_budget", 32'(i < maxc), 32'd1);
    repeat (2) @(negedge clk);
  endtask

  task automatic clear_counts(input int fulls, input int dzeros);
    full_ones = fulls;
    done_zeros = dzeros;
    rd_full_cnt = 0;
    rd_done_cnt = 0;
    bus_en_cnt = 0;
    done_cnt = 0;
    astr_cnt = 0;
    astr_full_snap = 0;
  endtask

  // GEMM model and write monitor, sampled mid-cycle.
  always @(negedge clk) begin
    wr_t e;
    nxt_rd = '0;
    if (bus_en === 1'b1) bus_en_cnt++;
    if (done === 1'b1) done_cnt++;
    if (bus_en === 1'b1 && rdwr === 1'b0) begin
      if (addr == BASE) begin
        rd_full_cnt++;
        if (full_ones > 0) begin
          nxt_rd = 32'd1;
          full_ones--;
        end
      end else if (addr == BASE + 32'd24) begin
        rd_done_cnt++;
        if (done_zeros > 0) done_zeros--;
        else nxt_rd = 32'd1;
      end
    end
    if (bus_en === 1'b1 && rdwr === 1'b1) begin
      if (addr == BASE + 32'd12) begin
        astr_cnt++;
        astr_full_snap = rd_full_cnt;
      end
      if (sb.size() > 0) e = sb.pop_front();
      else begin
        e.a = 32'hDEAD_BEEF;
        e.d = 32'hDEAD_BEEF;
      end
      check("wr_addr", addr, e.a);
      check("wr_data", wr_data, e.d);
    end
  end

  // Read data becomes valid the cycle after the request.
  always @(posedge clk) begin
    #1 rd_data = nxt_rd;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    int nb;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_bus_en", 32'(bus_en), 32'd0);
    check("rst_rdwr", 32'(rdwr), 32'd0);
    check("rst_addr", addr, 32'd0);
    check("rst_wr_data", wr_data, 32'd0);
    rst = 1'b0;

    // Single 16x16x16 tile, done on the third poll.
    clear_counts(0, 2);
    push_tile(16, 16, 0, 496, 512, 3, 16912);
    start_job(16, 16, 16, 0, 256, 512);
    wait_done(500);
    check("t1_sb_empty", sb.size(), 0);
    check("t1_done_pulses", done_cnt, 1);
    check("t1_done_polls", rd_done_cnt, 3);
    check("t1_full_polls", rd_full_cnt, 1);
    check("t1_busy_after", 32'(busy), 32'd0);

    // M=20: two m tiles, second one clipped to 4 rows.
    clear_counts(0, 2);
    push_tile(16, 16, 0, 496, 512, 3, 16912);
    push_tile(16, 16, 256, 496, 768, 3, 16900);
    start_job(20, 16, 16, 0, 256, 512);
    wait_done(500);
    check("t2_sb_empty", sb.size(), 0);
    check("t2_done_pulses", done_cnt, 1);

    // K=40: three k slices, ctrl 2/0/1, last slice 8 deep.
    clear_counts(0, 2);
    push_tile(40, 16, 0,  496, 512, 2, 16912);
    push_tile(40, 16, 16, 752, 512, 0, 16912);
    push_tile(40, 16, 32, 880, 512, 1, 16656);
    start_job(16, 40, 16, 0, 256, 512);
    wait_done(500);
    check("t3_sb_empty", sb.size(), 0);
    check("t3_done_pulses", done_cnt, 1);

    // N=20: two n tiles, second one 4 wide.
    clear_counts(0, 2);
    push_tile(16, 20, 0, 556, 512, 3, 16912);
    push_tile(16, 20, 0, 572, 528, 3, 4624);
    start_job(16, 16, 20, 0, 256, 512);
    wait_done(500);
    check("t4_sb_empty", sb.size(), 0);
    check("t4_done_pulses", done_cnt, 1);

    // Queue full for five reads after the first tile.
    clear_counts(5, 2);
    push_tile(16, 16, 0, 496, 512, 3, 16912);
    push_tile(16, 16, 256, 496, 768, 3, 16900);
    start_job(20, 16, 16, 0, 256, 512);
    wait_done(500);
    check("t5_sb_empty", sb.size(), 0);
    check("t5_full_polls", rd_full_cnt, 7);
    check("t5_astr_writes", astr_cnt, 2);
    check("t5_polls_before_2nd_tile", astr_full_snap, 6);
    check("t5_done_pulses", done_cnt, 1);

    // Zero dimension: immediate done, no bus traffic.
    clear_counts(0, 0);
    @(negedge clk);
    dim_m = 16; dim_k = 16; dim_n = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("t6_done_next", 32'(done), 32'd1);
    check("t6_busy_next", 32'(busy), 32'd0);
    @(negedge clk);
    check("t6_done_single", 32'(done), 32'd0);
    repeat (5) @(negedge clk);
    check("t6_bus_en_cnt", bus_en_cnt, 0);
    check("t6_done_pulses", done_cnt, 1);
    check("t6_busy_after", 32'(busy), 32'd0);

    // Reset during W_B of the second tile, then a clean replay.
    clear_counts(0, 2);
    push_tile(16, 16, 0, 496, 512, 3, 16912);
    push_tile(16, 16, 256, 496, 768, 3, 16900);
    start_job(20, 16, 16, 0, 256, 512);
    nb = 0;
    for (int i = 0; i < 200; i++) begin
      if (bus_en === 1'b1 && rdwr === 1'b1 && addr == BASE + 32'd4) nb++;
      if (nb == 2) break;
      @(negedge clk);
    end
    check("t7_reached_2nd_wb", nb, 2);
    rst = 1'b1;
    @(negedge clk);
    check("t7_busy_rst", 32'(busy), 32'd0);
    check("t7_bus_en_rst", 32'(bus_en), 32'd0);
    check("t7_done_rst", 32'(done), 32'd0);
    rst = 1'b0;
    sb.delete();
    repeat (3) @(negedge clk);
    check("t7_no_done_abort", done_cnt, 0);
    clear_counts(0, 2);
    push_tile(16, 16, 0, 496, 512, 3, 16912);
    start_job(16, 16, 16, 0, 256, 512);
    wait_done(500);
    check("t7_sb_empty", sb.size(), 0);
    check("t7_done_pulses", done_cnt, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
